// File: rtl/conv_3x3.sv
// ============================================================================
// conv_3x3
// ----------------------------------------------------------------------------
// One output column-lane of the 2-D convolution datapath. The block holds a
// 3x3 kernel (K) and a sliding 3x3 image window (W). Both are filled one
// 3-element column per accepted cycle. Every clock it emits the scaled sum of
// the nine K*W products.
//
// Pipeline (free-running, every clock):
//   edge E0 : K / W shift (only when i_valid=1)
//   edge E1 : the nine products are registered
//   edge E2 : the accumulator is registered; o_data is its top CONV_LPOS bits
//
// Ports
//   CLK100MHZ   in   1          clock, rising edge
//   rst         in   1          synchronous active-high reset
//   i_dato0     in   BIT_LEN    column element, row 0 (top)
//   i_dato1     in   BIT_LEN    column element, row 1 (middle)
//   i_dato2     in   BIT_LEN    column element, row 2 (bottom)
//   i_selecK_I  in   1          1: column goes to kernel, 0: column goes to window
//   i_valid     in   1          column is accepted this cycle
//   o_data      out  CONV_LPOS  acc[CONV_LEN-1 -: CONV_LPOS] (truncated, unsigned)
// ============================================================================
module conv_3x3 #(
    parameter int BIT_LEN   = 8,
    parameter int CONV_LEN  = 20,
    parameter int CONV_LPOS = 13
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic [BIT_LEN-1:0]   i_dato0,
    input  logic [BIT_LEN-1:0]   i_dato1,
    input  logic [BIT_LEN-1:0]   i_dato2,
    input  logic                 i_selecK_I,
    input  logic                 i_valid,
    output logic [CONV_LPOS-1:0] o_data
);

    localparam int PROD_LEN = 2 * BIT_LEN;

    // Incoming column, indexed by row.
    logic [BIT_LEN-1:0]  w_col    [0:2];

    // Kernel and window storage, [row][col]; col 2 holds the newest column.
    logic [BIT_LEN-1:0]  r_k      [0:2][0:2];
    logic [BIT_LEN-1:0]  r_w      [0:2][0:2];

    // Product registers, flattened as index = row*3 + col.
    logic [PROD_LEN-1:0] r_prod   [0:8];

    logic [CONV_LEN-1:0] w_sum;
    logic [CONV_LEN-1:0] r_acc;

    logic                w_shift_k;
    logic                w_shift_w;

    assign w_col[0] = i_dato0;
    assign w_col[1] = i_dato1;
    assign w_col[2] = i_dato2;

    // A column is routed to exactly one of the two arrays, and only when valid.
    assign w_shift_k = i_valid &  i_selecK_I;
    assign w_shift_w = i_valid & ~i_selecK_I;

    // ------------------------------------------------------------------
    // E0: kernel / window shift registers, one process per row
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            always_ff @(posedge CLK100MHZ) begin
                if (rst) begin
                    r_k[gi][0] <= '0;
                    r_k[gi][1] <= '0;
                    r_k[gi][2] <= '0;
                end else if (w_shift_k) begin
                    r_k[gi][0] <= r_k[gi][1];
                    r_k[gi][1] <= r_k[gi][2];
                    r_k[gi][2] <= w_col[gi];
                end
            end

            always_ff @(posedge CLK100MHZ) begin
                if (rst) begin
                    r_w[gi][0] <= '0;
                    r_w[gi][1] <= '0;
                    r_w[gi][2] <= '0;
                end else if (w_shift_w) begin
                    r_w[gi][0] <= r_w[gi][1];
                    r_w[gi][1] <= r_w[gi][2];
                    r_w[gi][2] <= w_col[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // E1: nine registered products
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prod
            always_ff @(posedge CLK100MHZ) begin
                if (rst) begin
                    r_prod[gi] <= '0;
                end else begin
                    r_prod[gi] <= PROD_LEN'(r_k[gi / 3][gi % 3]) *
                                  PROD_LEN'(r_w[gi / 3][gi % 3]);
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // E2: adder tree into the accumulator register
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) begin
            w_sum = w_sum + CONV_LEN'(r_prod[i]);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum;
        end
    end

    // Plain truncation: the low bits are dropped, so kernel value 128 is unity gain.
    assign o_data = r_acc[CONV_LEN-1 -: CONV_LPOS];

    // The dropped low bits are intentionally not used anywhere.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^r_acc[CONV_LEN-CONV_LPOS-1:0];

endmodule

// File: tb/tb_conv_3x3.sv
// ============================================================================
// tb_conv_3x3
// ----------------------------------------------------------------------------
// Directed-vector bench for conv_3x3. Inputs change 1 ns after a rising edge
// and o_data is sampled at the same point, so every read sees the state left
// by the edge just taken. Expected values are computed by hand.
// ============================================================================
`timescale 1ns/1ps
module tb_conv_3x3;

    logic        CLK100MHZ = 1'b0;
    logic        rst       = 1'b1;
    logic [7:0]  i_dato0   = '0;
    logic [7:0]  i_dato1   = '0;
    logic [7:0]  i_dato2   = '0;
    logic        i_selecK_I = 1'b0;
    logic        i_valid   = 1'b0;
    logic [12:0] o_data;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    conv_3x3 #(
        .BIT_LEN   (8),
        .CONV_LEN  (20),
        .CONV_LPOS (13)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .rst        (rst),
        .i_dato0    (i_dato0),
        .i_dato1    (i_dato1),
        .i_dato2    (i_dato2),
        .i_selecK_I (i_selecK_I),
        .i_valid    (i_valid),
        .o_data     (o_data)
    );

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: o_data=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: o_data=%0d", tag, got);
        end
    endtask

    // Apply one cycle of inputs, take the rising edge, settle 1 ns past it.
    task automatic step(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic sel, input logic vld, input logic r);
        i_dato0    = d0;
        i_dato1    = d1;
        i_dato2    = d2;
        i_selecK_I = sel;
        i_valid    = vld;
        rst        = r;
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic kcol(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        step(d0, d1, d2, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic icol(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        step(d0, d1, d2, 1'b0, 1'b1, 1'b0);
    endtask

    // Idle cycle with random data on the bus; i_valid=0 so nothing may move.
    task automatic idle(input logic sel);
        step(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
             8'($urandom_range(255, 0)), sel, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        // Reset for 2 cycles with random data and valid asserted (rst wins).
        for (int i = 0; i < 2; i++) begin
            step(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), 1'b1, 1'b1);
            chk($sformatf("reset_cyc%0d", i), o_data, 13'd0);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'(i));
            chk($sformatf("post_reset_idle%0d", i), o_data, 13'd0);
        end

        // Identity kernel; image middle row 10,20,30 -> centre 20.
        kcol(8'd0, 8'd0,   8'd0);
        kcol(8'd0, 8'd128, 8'd0);
        kcol(8'd0, 8'd0,   8'd0);
        icol(8'd0, 8'd10, 8'd0);
        icol(8'd0, 8'd20, 8'd0);
        icol(8'd0, 8'd30, 8'd0);
        chk("ident_lat0", o_data, 13'd0);   // reflects window after 1st push
        idle(1'b0);
        chk("ident_lat1", o_data, 13'd10);  // window after 2nd push
        idle(1'b0);
        chk("ident_lat2", o_data, 13'd20);

        // Full scale: 9*255*255 = 585225, >>7 = 4572.
        for (int i = 0; i < 3; i++) kcol(8'd255, 8'd255, 8'd255);
        for (int i = 0; i < 3; i++) icol(8'd255, 8'd255, 8'd255);
        idle(1'b0);
        idle(1'b1);
        chk("full_scale", o_data, 13'd4572);

        // Hold: random data, selector toggling, valid low.
        for (int i = 0; i < 4; i++) begin
            idle(1'(i));
            chk($sformatf("hold%0d", i), o_data, 13'd4572);
        end

        // Kernel pushes must leave the window of 255s untouched.
        for (int i = 0; i < 3; i++) kcol(8'd0, 8'd0, 8'd0);
        idle(1'b0);
        idle(1'b0);
        chk("sep_k_zero", o_data, 13'd0);
        kcol(8'd0, 8'd0,   8'd0);
        kcol(8'd0, 8'd128, 8'd0);
        kcol(8'd0, 8'd0,   8'd0);
        idle(1'b0);
        idle(1'b0);
        chk("sep_w_kept", o_data, 13'd255);

        // Corners: K00=255*W00=100 + K22=200*W22=64 = 38300, >>7 = 299.
        kcol(8'd255, 8'd0, 8'd0);
        kcol(8'd0,   8'd0, 8'd0);
        kcol(8'd0,   8'd0, 8'd200);
        icol(8'd100, 8'd7, 8'd7);
        icol(8'd7,   8'd7, 8'd7);
        icol(8'd7,   8'd7, 8'd64);
        idle(1'b1);
        idle(1'b0);
        chk("corners", o_data, 13'd299);

        // Mixed kernel 1..9 against image 10..90: sum 2850, >>7 = 22.
        kcol(8'd1, 8'd2, 8'd3);
        kcol(8'd4, 8'd5, 8'd6);
        kcol(8'd7, 8'd8, 8'd9);
        icol(8'd10, 8'd20, 8'd30);
        icol(8'd40, 8'd50, 8'd60);
        icol(8'd70, 8'd80, 8'd90);
        idle(1'b0);
        idle(1'b0);
        chk("mixed", o_data, 13'd22);

        // Mid-stream reset, asserted together with a valid image push.
        icol(8'd200, 8'd200, 8'd200);
        step(8'd99, 8'd99, 8'd99, 1'b0, 1'b1, 1'b1);
        chk("midrst_now", o_data, 13'd0);
        for (int i = 0; i < 3; i++) icol(8'd50, 8'd50, 8'd50);
        idle(1'b0);
        idle(1'b0);
        chk("midrst_nokernel", o_data, 13'd0);

        // Reloading the identity kernel exposes the new window centre.
        kcol(8'd0, 8'd0,   8'd0);
        kcol(8'd0, 8'd128, 8'd0);
        kcol(8'd0, 8'd0,   8'd0);
        idle(1'b0);
        idle(1'b0);
        chk("midrst_reload", o_data, 13'd50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
